// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared types, defaults and edge qualification for multi_edge_capture
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned DEF_CHANNELS        = 8;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W           = 8;

  function automatic logic edge_qualify(input edge_mode_e mode, input logic filt,
                                        input logic prev);
    logic rise_en;
    logic fall_en;
    rise_en = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    fall_en = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    return (rise_en & filt & ~prev) | (fall_en & ~filt & prev);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one capture channel: synchroniser, optional debounce (EDGE_DEBOUNCE_EN), qualify, pending, counter
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
`ifdef EDGE_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`endif
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pulse_i,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  output logic             edge_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] count_o,
  output logic             pending_next_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   filt;
  logic                   prev_q;
  logic                   edge_d;
  logic [CNT_W-1:0]       count_next;
  edge_mode_e             mode;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q;
  logic            filt_q;

  // The filtered level only follows the synchroniser after it has disagreed for a full run.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else if (sync_lvl == filt_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_q <= '0;
      filt_q   <= sync_lvl;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_lvl;
`endif

  assign mode = edge_mode_e'(mode_i);

  always_comb begin
    edge_d         = edge_qualify(mode, filt, prev_q);
    pending_next_o = edge_d | (pending_o & ~clear_i);
    count_next     = count_o;
    if (clear_i) begin
      count_next = edge_d ? CNT_W'(1) : '0;
    end else if (edge_d && (count_o != {CNT_W{1'b1}})) begin
      count_next = count_o + CNT_W'(1);
    end
  end

  // prev tracks the filtered level even while the channel is off, so enabling never shows a stale edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q    <= 1'b0;
      edge_o    <= 1'b0;
      pending_o <= 1'b0;
      count_o   <= '0;
    end else begin
      prev_q    <= filt;
      edge_o    <= edge_d;
      pending_o <= pending_next_o;
      count_o   <= count_next;
    end
  end

endmodule

// File: rtl/multi_edge_capture.sv
// rtl/multi_edge_capture.sv - multi-channel edge capture with interrupt; debounce built when EDGE_DEBOUNCE_EN is defined
module multi_edge_capture
  import edge_pkg::*;
#(
  parameter int unsigned CHANNELS        = DEF_CHANNELS,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [CHANNELS-1:0]       pulse_i,
  input  logic [2*CHANNELS-1:0]     mode_i,
  input  logic [CHANNELS-1:0]       clear_i,
  output logic [CHANNELS-1:0]       edge_o,
  output logic [CHANNELS-1:0]       pending_o,
  output logic [CHANNELS*CNT_W-1:0] count_o,
  output logic                      irq_o
);

  logic [CHANNELS-1:0] pending_next;

  // Illegal parameter sets build an inert block rather than half-working channels.
  if (CHANNELS >= 1 && SYNC_STAGES >= 2 && DEBOUNCE_CYCLES >= 1 && CNT_W >= 1) begin : g_cfg_ok
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      edge_chan #(
        .SYNC_STAGES    (SYNC_STAGES),
`ifdef EDGE_DEBOUNCE_EN
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`endif
        .CNT_W          (CNT_W)
      ) u_chan (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pulse_i        (pulse_i[c]),
        .mode_i         (mode_i[2*c +: 2]),
        .clear_i        (clear_i[c]),
        .edge_o         (edge_o[c]),
        .pending_o      (pending_o[c]),
        .count_o        (count_o[c*CNT_W +: CNT_W]),
        .pending_next_o (pending_next[c])
      );
    end
  end else begin : g_cfg_bad
    assign edge_o       = '0;
    assign pending_o    = '0;
    assign count_o      = '0;
    assign pending_next = '0;
  end

  // Built from the next-state pending bits so irq_o changes on the same edge as pending_o.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |pending_next;
    end
  end

endmodule
